// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART TX/RX blocks, their FIFOs and the MMIO
// bridge: the data width, the default FIFO depth and the byte type that
// travels between them.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// DEPTH x byte register array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset; the
// owning FIFO tracks validity with its own pointers and level counter.
//
// Ports:
//   clk_i    in   write clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write byte
//   raddr_i  in   read address
//   rdata_o  out  byte stored at raddr_i
// -----------------------------------------------------------------------------
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  uart_byte_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output uart_byte_t    rdata_o
);

    uart_byte_t mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_ram

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO between the CPU MMIO write path and the UART transmitter. Bytes
// are pushed at full clock rate and drained one at a time through the
// transmitter's tx_avai / tx_start / tx_data handshake.
//
// Ports:
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   wr_en     in   push request (one byte per cycle)
//   wr_data   in   byte to push
//   flush     in   discard all queued bytes
//   ovf_clr   in   clear sticky overflow flag
//   tx_avai   in   transmitter idle
//   tx_start  out  launch transmission of tx_data (combinational)
//   tx_data   out  head-of-queue byte (combinational, valid when !empty)
//   full      out  level == DEPTH
//   empty     out  level == 0
//   level     out  number of queued bytes, 0..DEPTH
//   overflow  out  sticky: a push was dropped because the queue was full
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_en,
    input  uart_byte_t  wr_data,
    input  logic        flush,
    input  logic        ovf_clr,
    input  logic        tx_avai,
    output logic        tx_start,
    output uart_byte_t  tx_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        overflow
);

    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;

    logic push_acc;
    logic push_drop;
    logic pop;

    // Full/empty come from the level counter alone, so rp == wp is never
    // ambiguous.
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == LVL_ZERO);
    assign level = level_q;
    assign overflow = ovf_q;

    // A push into a full queue is dropped even when a pop frees a slot in the
    // same cycle; there is no pass-through path.
    assign push_acc  = wr_en && !full && !flush;
    assign push_drop = wr_en &&  full && !flush;

    // Launch depends on empty, which is derived from the asynchronously reset
    // level register, so tx_start drops immediately when rstn asserts.
    assign tx_start = tx_avai && !empty && !flush;
    assign pop      = tx_start;

    uart_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push_acc),
        .waddr_i (wp_q),
        .wdata_i (wr_data),
        .raddr_i (rp_q),
        .rdata_o (tx_data)
    );

    // Next-state for pointers and level; flush overrides everything.
    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        level_d = level_q;
        if (flush) begin
            rp_d    = PTR_ZERO;
            wp_d    = PTR_ZERO;
            level_d = LVL_ZERO;
        end else begin
            if (push_acc) begin
                wp_d = wp_q + PTR_ONE;
            end else begin
                wp_d = wp_q;
            end
            if (pop) begin
                rp_d = rp_q + PTR_ONE;
            end else begin
                rp_d = rp_q;
            end
            case ({push_acc, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Sticky overflow: a dropped push wins over a same-cycle clear; flush
    // leaves it alone.
    always_comb begin
        ovf_d = ovf_q;
        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rp_q    <= PTR_ZERO;
            wp_q    <= PTR_ZERO;
            level_q <= LVL_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule : uart_tx_fifo

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that sits directly upstream of the UART transmitter. It accepts bytes from the CPU-side MMIO write path at full clock rate and buffers them. It drains them one at a time into the transmitter through that block's `tx_start` / `tx_data` / `tx_avai` handshake. Software can queue a burst of characters without polling transmitter idle between bytes.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, 2..256.
- `AW`, $clog2(DEPTH): pointer width; derived, not overridden.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  push request from the bus side, one byte per cycle.
- `wr_data`  in  8  byte to push.
- `flush`  in  1  discard all queued bytes.
- `ovf_clr`  in  1  clear the sticky overflow flag.
- `tx_avai`  in  1  transmitter idle; from the transmitter.
- `tx_start`  out  1  launch transmission of `tx_data`; to the transmitter.
- `tx_data`  out  8  head-of-queue byte.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `level`  out  AW+1  number of queued bytes, 0..DEPTH.
- `overflow`  out  1  sticky: a push was dropped.

## Operation
- Storage: DEPTH×8 array, read pointer `rp` and write pointer `wp` (AW bits, wrap modulo DEPTH), and counter `level` (AW+1 bits). Full and empty are derived from `level` only, never from pointer compare.
- Push accepted: `wr_en && !full && !flush`. Effect: `mem[wp] <= wr_data`, `wp <= wp+1`.
- Push dropped: `wr_en && full && !flush`. Effect: `overflow <= 1`; memory, pointers and level are unchanged. There is no same-cycle pass-through, even if a pop occurs in that cycle.
- Pop: `tx_start && !flush`. Effect: `rp <= rp+1`.
- `tx_start = tx_avai && !empty && !flush`, combinational.
- `tx_data = mem[rp]`, combinational, valid whenever `!empty`. It shows the last head value when empty; consumers ignore it then.
- Level update is +1 on push only, −1 on pop only, and unchanged on both or neither.
- Flush: `rp <= 0`, `wp <= 0`, `level <= 0`. Memory contents are not cleared. Flush does not affect a byte already handed to the transmitter.
- Overflow: set by a dropped push and cleared by `ovf_clr`. If both happen in the same cycle, set wins. Flush does not clear overflow.
- The block has no FSM. The transmitter's own state gates draining via `tx_avai`.

## Timing
- Reset values: `rp = wp = 0`, `level = 0`, `overflow = 0`. The reset-derived outputs are `empty = 1`, `full = 0`, `tx_start = 0`. Memory is not reset.
- Write-to-launch latency: a byte pushed at edge N into an empty FIFO with `tx_avai = 1` produces `tx_start = 1` in the cycle after edge N, and the pop happens at edge N+1.
- Handshake: the transmitter samples `tx_start` / `tx_data` at the edge where it is in IDLE. `tx_avai` falls the cycle after, so `tx_start` is high for exactly one cycle per byte.
- Back-to-back: the next byte launches in the first cycle `tx_avai` returns high, with no gap cycle added by this block.
- Full with simultaneous push and pop: the pop succeeds and the push is dropped. Overflow is set and level becomes DEPTH−1.
- Reset asserted mid-operation: queue contents are lost immediately (asynchronously). `tx_start` falls without waiting for a clock edge.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W = 8`;
  - default `UART_FIFO_DEPTH = 16`;
  - the byte typedef `uart_byte_t`, shared with the TX/RX blocks and the MMIO bridge.
- One natural sub-module, `uart_fifo_ram`: the DEPTH×8 register array with a synchronous write port and an asynchronous read port. It is reusable for a future RX FIFO.
- Pointer, level and flag logic stays in `uart_tx_fifo`.

## Test plan
- **Reset:** assert `rstn = 0` mid-burst with level 5 → `level = 0`, `empty = 1`, `tx_start = 0` asynchronously. After release, no spurious `tx_start`.
- **Ordered drain:** hold `tx_avai = 0` and push 0x41, 0x42, 0x43. Then model the transmitter (busy 10 cycles after each start) → exactly three one-cycle `tx_start` pulses with `tx_data` 0x41, 0x42, 0x43, and level ending at 0.
- **Fill and overflow:** with `tx_avai = 0`, push 17 bytes into DEPTH = 16 → `full = 1`, `level = 16`, `overflow = 1`. The 17th byte never appears on `tx_data`. Then `ovf_clr` → `overflow = 0`.
- **Full with push and pop together:** at level 16 pulse `tx_avai = 1` while pushing 0x99 → `level = 15`, `overflow = 1`, and 0x99 is absent from the drained sequence.
- **Pointer wrap:** stream 40 bytes 0x00..0x27 with interleaved draining, so pointers wrap at least twice → output matches input order exactly.
- **Flush:** at level 6, assert `flush` with `wr_en` and `tx_avai` both high → `tx_start = 0` that cycle and `level = 0` next. The pushed byte is discarded and `overflow` is unchanged.
